led_driver: RTL and testbench

- Memory-mapped write/read interface between the 4-way handshaking data bus and 8 physical LEDs; the output-side counterpart of the debounced switch input block.
- Holds an LED value register and a control register (per-LED blink mask, global brightness).
- Drives the LED pins through a free-running blink prescaler and a PWM dimmer.
- Sits on the SoC I/O bus beside the switch reader and is selected by the address decoder via Read/Write.

---
 rtl/led_driver.sv | 122 ++++++++++++
 tb/tb_led_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_driver.sv
// LED output port on the SoC I/O bus: an 8-bit value register and a control
// register (per-LED blink mask, global brightness), driven out through a
// free-running blink prescaler and a PWM dimmer. Bus side uses a 4-way
// Read/Write/Ack handshake with a single commit or capture per handshake.
module led_driver #(
   parameter int unsigned BLINK_DIV = 25000000,
   parameter int unsigned PWM_BITS  = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Read,
   input  logic        Write,
   input  logic        Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        Ack,
   output logic [7:0]  LED
);

   localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CntW-1:0] BlinkLast = CntW'(BLINK_DIV - 1);

   logic [7:0]          value;
   logic [7:0]          mask;
   logic [PWM_BITS-1:0] bright;
   logic [CntW-1:0]     blink_cnt;
   logic                blink_phase;
   logic [PWM_BITS-1:0] pwm_cnt;

   logic        req;
   logic        new_req;
   logic        do_write;
   logic        do_read;
   logic        pwm_on;
   logic [31:0] ctrl_word;
   logic [7:0]  led_next;
   logic        unused_data;

   // Only the first cycle of a request (Ack still low) is acted upon.
   assign req      = Read | Write;
   assign new_req  = req & ~Ack;
   assign do_write = new_req & Write;
   assign do_read  = new_req & Read & ~Write;

   // Full brightness is forced on so the counter wrap never leaves a dark cycle.
   assign pwm_on = (&bright) | (pwm_cnt < bright);

   assign unused_data = ^DataIn[31:8+PWM_BITS];

   // Read-back image of the control register, zero-extended.
   always_comb begin
      ctrl_word                  = '0;
      ctrl_word[7:0]             = mask;
      ctrl_word[8 +: PWM_BITS]   = bright;
   end

   // Per-LED drive: masked LEDs follow the blink phase, all LEDs gated by PWM.
   always_comb begin
      led_next = value & {8{pwm_on}} & (~mask | {8{blink_phase}});
   end

   // Handshake acknowledge and registered read data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Ack     <= 1'b0;
         DataOut <= '0;
      end else begin
         Ack <= req;
         if (do_read) begin
            DataOut <= Address ? ctrl_word : {24'b0, value};
         end
      end
   end

   // Register file: committed once per write handshake.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value  <= '0;
         mask   <= '0;
         bright <= '1;
      end else if (do_write) begin
         if (Address) begin
            mask   <= DataIn[7:0];
            bright <= DataIn[8 +: PWM_BITS];
         end else begin
            value <= DataIn[7:0];
         end
      end
   end

   // Free-running blink prescaler; phase toggles each BLINK_DIV cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (blink_cnt == BlinkLast) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Free-running PWM counter, wraps naturally at all ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // Registered LED pins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         LED <= '0;
      end else begin
         LED <= led_next;
      end
   end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: a cycle-count based reference model
// checked every cycle, plus directed literal checks and random bus traffic.
module tb_led_driver;

   localparam int unsigned BlinkDiv = 4;
   localparam int unsigned PwmBits  = 4;
   localparam int          PwmMod   = 1 << PwmBits;

   logic        clock;
   logic        reset;
   logic        Read;
   logic        Write;
   logic        Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        Ack;
   logic [7:0]  LED;

   int n_checks = 0;
   int n_fail   = 0;

   led_driver #(
      .BLINK_DIV (BlinkDiv),
      .PWM_BITS  (PwmBits)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .Read    (Read),
      .Write   (Write),
      .Address (Address),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .Ack     (Ack),
      .LED     (LED)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Counters are derived from k, the number of clock edges since reset release.
   logic [7:0]         m_value;
   logic [7:0]         m_mask;
   logic [PwmBits-1:0] m_bright;
   logic               m_ack;
   logic [31:0]        m_dout;
   logic [7:0]         m_led;
   int                 k;

   function automatic logic f_pwm_on(input int kk, input logic [PwmBits-1:0] b);
      return (int'(b) == PwmMod - 1) || ((kk % PwmMod) < int'(b));
   endfunction

   function automatic logic f_phase(input int kk);
      return ((kk / BlinkDiv) % 2) == 0;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_value  <= '0;
         m_mask   <= '0;
         m_bright <= '1;
         m_ack    <= 1'b0;
         m_dout   <= '0;
         m_led    <= '0;
         k        <= 0;
      end else begin
         m_led <= m_value & {8{f_pwm_on(k, m_bright)}} & (~m_mask | {8{f_phase(k)}});
         if ((Read || Write) && !m_ack) begin
            if (Write) begin
               if (Address) begin
                  m_mask   <= DataIn[7:0];
                  m_bright <= DataIn[8 +: PwmBits];
               end else begin
                  m_value <= DataIn[7:0];
               end
            end else begin
               m_dout <= Address ? {16'b0, 4'b0, m_bright, m_mask} : {24'b0, m_value};
            end
         end
         m_ack <= Read || Write;
         k     <= k + 1;
      end
   end

   // Cycle-by-cycle compare, away from the active edge.
   always @(negedge clock) begin
      if (reset) begin
         check("model_led", {24'b0, LED}, {24'b0, m_led});
         check("model_ack", {31'b0, Ack}, {31'b0, m_ack});
         check("model_dout", DataOut, m_dout);
      end
   end

   // ---------------- stimulus ----------------
   task automatic bus_txn(input logic rd, input logic wr, input logic addr,
                          input logic [31:0] data, input int hold, input logic scramble);
      int waited;
      @(negedge clock);
      Read = rd; Write = wr; Address = addr; DataIn = data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         if (scramble) begin
            DataIn  = $urandom;
            Address = 1'($urandom_range(0, 1));
         end
      end
      Read = 1'b0; Write = 1'b0;
      waited = 0;
      do begin
         @(negedge clock);
         waited++;
      end while (Ack && waited < 8);
      check("ack_release", {31'b0, Ack}, 32'h0);
   endtask

   task automatic count_led0(input int cycles, output int hits);
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (LED[0]) hits++;
      end
   endtask

   initial begin
      int hits;
      int n_ff;
      int n_f0;
      int n_other;
      int op;

      reset = 1'b0; Read = 1'b0; Write = 1'b0; Address = 1'b0; DataIn = '0;
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      repeat (3) @(negedge clock);

      // 1: reset state and control read-back
      check("reset_led", {24'b0, LED}, 32'h0);
      check("reset_ack", {31'b0, Ack}, 32'h0);
      check("reset_dout", DataOut, 32'h0);
      bus_txn(1'b1, 1'b0, 1'b1, 32'h0, 2, 1'b0);
      check("rd_ctrl_reset", DataOut, 32'h0000_0F00);

      // 2: long write with data changed mid-hold commits once
      @(negedge clock);
      Write = 1'b1; Address = 1'b0; DataIn = 32'h0000_00A5;
      @(negedge clock);
      check("ack_rise", {31'b0, Ack}, 32'h1);
      @(negedge clock);
      check("led_after_write", {24'b0, LED}, 32'hA5);
      DataIn = 32'h0000_005A;
      repeat (3) @(negedge clock);
      check("ack_held", {31'b0, Ack}, 32'h1);
      check("led_single_commit", {24'b0, LED}, 32'hA5);
      Write = 1'b0;
      @(negedge clock);
      check("ack_fall", {31'b0, Ack}, 32'h0);

      // 5: simultaneous Read and Write
      bus_txn(1'b0, 1'b1, 1'b0, 32'h11, 2, 1'b0);
      bus_txn(1'b1, 1'b0, 1'b0, 32'h0, 2, 1'b0);
      check("rd_value", DataOut, 32'h11);
      bus_txn(1'b1, 1'b1, 1'b0, 32'h3C, 2, 1'b0);
      check("rw_dout_held", DataOut, 32'h11);
      bus_txn(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      check("rw_value", DataOut, 32'h3C);

      // 3: blink on the low nibble only
      bus_txn(1'b0, 1'b1, 1'b0, 32'hFF, 1, 1'b0);
      bus_txn(1'b0, 1'b1, 1'b1, 32'h0000_0F0F, 1, 1'b0);
      n_ff = 0; n_f0 = 0; n_other = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         if (LED == 8'hFF) n_ff++;
         else if (LED == 8'hF0) n_f0++;
         else n_other++;
      end
      check("blink_on_cycles", n_ff, 8);
      check("blink_off_cycles", n_f0, 8);
      check("blink_other", n_other, 0);

      // 4: PWM duty
      bus_txn(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1, 1'b0);
      bus_txn(1'b0, 1'b1, 1'b0, 32'h01, 1, 1'b0);
      count_led0(16, hits);
      check("pwm_duty_4", hits, 4);
      bus_txn(1'b0, 1'b1, 1'b1, 32'h0, 1, 1'b0);
      count_led0(16, hits);
      check("pwm_duty_0", hits, 0);
      bus_txn(1'b0, 1'b1, 1'b1, 32'h0000_0F00, 1, 1'b0);
      count_led0(16, hits);
      check("pwm_duty_full", hits, 16);

      // random traffic, checked by the model every cycle
      for (int t = 0; t < 80; t++) begin
         op = int'($urandom_range(0, 2));
         bus_txn(op != 1, op != 0, 1'($urandom_range(0, 1)), $urandom,
                 int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      // 6: asynchronous reset mid-write, release with Write still held
      bus_txn(1'b0, 1'b1, 1'b1, 32'h0000_0F00, 1, 1'b0);
      @(negedge clock);
      Write = 1'b1; Address = 1'b0; DataIn = 32'h77;
      @(negedge clock);
      check("ack_before_reset", {31'b0, Ack}, 32'h1);
      #2 reset = 1'b0;
      #1;
      check("async_ack", {31'b0, Ack}, 32'h0);
      check("async_led", {24'b0, LED}, 32'h0);
      check("async_dout", DataOut, 32'h0);
      @(negedge clock);
      #2 reset = 1'b1;
      @(posedge clock);
      #1;
      check("ack_after_release", {31'b0, Ack}, 32'h1);
      @(posedge clock);
      #1;
      check("led_after_release", {24'b0, LED}, 32'h77);
      @(negedge clock);
      Write = 1'b0;
      repeat (3) @(negedge clock);
      check("final_ack", {31'b0, Ack}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
